// File: rtl/dsi_packet_rx.sv
// Byte-serial MIPI DSI packet receiver: header parse with Hamming ECC correction,
// long-packet payload streaming and CRC-16 check. All outputs are registered.
module dsi_packet_rx #(
  parameter bit          ECC_CORRECT = 1'b1,
  parameter int unsigned MAX_WC      = 4096,
  parameter bit          CRC_ZERO_OK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_sot,
  input  logic        in_eot,
  output logic        hdr_valid,
  output logic [1:0]  hdr_vc,
  output logic [5:0]  hdr_dt,
  output logic [15:0] hdr_wc,
  output logic        hdr_long,
  output logic        ecc_corr,
  output logic        ecc_err,
  output logic        wc_err,
  output logic        pl_valid,
  output logic [7:0]  pl_data,
  output logic        pl_last,
  output logic        pkt_done,
  output logic        crc_ok,
  output logic        err_trunc
);

  typedef enum logic [2:0] {StIdle, StHdr, StPayload, StCrc, StSkip} state_e;

  // Parity coverage masks over D[23:0]; bit i of PkM set when data bit i feeds ECC bit k.
  localparam logic [23:0] P0M = 24'hF12CB7;
  localparam logic [23:0] P1M = 24'hF2555B;
  localparam logic [23:0] P2M = 24'h749A6D;
  localparam logic [23:0] P3M = 24'hB8E38E;
  localparam logic [23:0] P4M = 24'hDF03F0;
  localparam logic [23:0] P5M = 24'hEFFC00;

  function automatic logic [5:0] ecc_calc(input logic [23:0] d);
    return {^(d & P5M), ^(d & P4M), ^(d & P3M), ^(d & P2M), ^(d & P1M), ^(d & P0M)};
  endfunction

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  hcnt_q, hcnt_d;
  logic [7:0]  di_q, di_d, wclo_q, wclo_d, wchi_q, wchi_d, crc_lo_q, crc_lo_d;
  logic [15:0] rem_q, rem_d, crc_q, crc_d;

  logic        hdr_valid_q, hdr_valid_d, hdr_long_q, hdr_long_d;
  logic [1:0]  hdr_vc_q, hdr_vc_d;
  logic [5:0]  hdr_dt_q, hdr_dt_d;
  logic [15:0] hdr_wc_q, hdr_wc_d;
  logic        ecc_corr_q, ecc_corr_d, ecc_err_q, ecc_err_d, wc_err_q, wc_err_d;
  logic        pl_valid_q, pl_valid_d, pl_last_q, pl_last_d;
  logic [7:0]  pl_data_q, pl_data_d;
  logic        pkt_done_q, pkt_done_d, crc_ok_q, crc_ok_d, err_trunc_q, err_trunc_d;

  // Header decode, valid when in_data is the ECC byte.
  logic [23:0] hdr_raw, hdr_fix, hdr_sel;
  logic [5:0]  syn;
  logic        col_hit, dec_corr, dec_err, dec_long, dec_wcerr;
  logic [15:0] dec_wc;
  logic [15:0] crc_rx;

  always_comb begin
    hdr_raw = {wchi_q, wclo_q, di_q};
    syn     = ecc_calc(hdr_raw) ^ in_data[5:0];
    hdr_fix = hdr_raw;
    col_hit = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (syn == {P5M[i], P4M[i], P3M[i], P2M[i], P1M[i], P0M[i]}) begin
        hdr_fix[i] = ~hdr_raw[i];
        col_hit    = 1'b1;
      end
    end
    dec_corr = 1'b0;
    dec_err  = 1'b0;
    if (in_data[7:6] != 2'b00) begin
      dec_err = 1'b1;
    end else if (syn != 6'd0) begin
      if (ECC_CORRECT && ($onehot(syn) || col_hit)) dec_corr = 1'b1;
      else                                          dec_err  = 1'b1;
    end
    hdr_sel   = dec_err ? hdr_raw : hdr_fix;
    dec_long  = hdr_sel[3] & (|hdr_sel[2:0]);
    dec_wc    = hdr_sel[23:8];
    dec_wcerr = !dec_err && dec_long && (32'(dec_wc) > MAX_WC);
    crc_rx    = {in_data, crc_lo_q};
  end

  logic take_b0, trunc;

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    di_d        = di_q;
    wclo_d      = wclo_q;
    wchi_d      = wchi_q;
    rem_d       = rem_q;
    crc_d       = crc_q;
    crc_lo_d    = crc_lo_q;
    hdr_valid_d = 1'b0;
    hdr_vc_d    = hdr_vc_q;
    hdr_dt_d    = hdr_dt_q;
    hdr_wc_d    = hdr_wc_q;
    hdr_long_d  = hdr_long_q;
    ecc_corr_d  = 1'b0;
    ecc_err_d   = 1'b0;
    wc_err_d    = 1'b0;
    pl_valid_d  = 1'b0;
    pl_data_d   = pl_data_q;
    pl_last_d   = 1'b0;
    pkt_done_d  = 1'b0;
    crc_ok_d    = 1'b0;
    err_trunc_d = 1'b0;
    take_b0     = 1'b0;
    trunc       = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        StIdle: take_b0 = in_sot;
        StHdr: begin
          if (in_sot || hcnt_q == 2'd0) begin
            take_b0     = 1'b1;
            err_trunc_d = in_sot && (hcnt_q != 2'd0);
          end else if (hcnt_q == 2'd1) begin
            wclo_d = in_data;
            hcnt_d = 2'd2;
            trunc  = in_eot;
          end else if (hcnt_q == 2'd2) begin
            wchi_d = in_data;
            hcnt_d = 2'd3;
            trunc  = in_eot;
          end else begin
            hdr_valid_d = 1'b1;
            hdr_vc_d    = hdr_sel[7:6];
            hdr_dt_d    = hdr_sel[5:0];
            hdr_wc_d    = dec_wc;
            hdr_long_d  = dec_long;
            ecc_corr_d  = dec_corr;
            ecc_err_d   = dec_err;
            wc_err_d    = dec_wcerr;
            crc_d       = 16'hFFFF;
            hcnt_d      = 2'd0;
            if (dec_err || dec_wcerr) begin
              state_d = in_eot ? StIdle : StSkip;
            end else if (!dec_long) begin
              pkt_done_d = 1'b1;
              crc_ok_d   = 1'b1;
              state_d    = in_eot ? StIdle : StHdr;
            end else begin
              state_d = (dec_wc == 16'd0) ? StCrc : StPayload;
              rem_d   = dec_wc;
              trunc   = in_eot;
            end
          end
        end
        StPayload: begin
          if (in_sot) begin
            take_b0     = 1'b1;
            err_trunc_d = 1'b1;
          end else begin
            pl_valid_d = 1'b1;
            pl_data_d  = in_data;
            pl_last_d  = (rem_q == 16'd1);
            crc_d      = crc_byte(crc_q, in_data);
            rem_d      = rem_q - 16'd1;
            if (rem_q == 16'd1) state_d = StCrc;
            hcnt_d = 2'd0;
            trunc  = in_eot;
          end
        end
        StCrc: begin
          if (in_sot) begin
            take_b0     = 1'b1;
            err_trunc_d = 1'b1;
          end else if (hcnt_q == 2'd0) begin
            crc_lo_d = in_data;
            hcnt_d   = 2'd1;
            trunc    = in_eot;
          end else begin
            pkt_done_d = 1'b1;
            crc_ok_d   = (crc_rx == crc_q) || (CRC_ZERO_OK && crc_rx == 16'd0);
            hcnt_d     = 2'd0;
            state_d    = in_eot ? StIdle : StHdr;
          end
        end
        StSkip: begin
          if (in_sot)      take_b0 = 1'b1;
          else if (in_eot) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
      // A burst-start byte always opens a fresh header, even mid-packet.
      if (take_b0) begin
        di_d    = in_data;
        hcnt_d  = 2'd1;
        state_d = StHdr;
        trunc   = in_eot;
      end
      if (trunc) begin
        err_trunc_d = 1'b1;
        state_d     = StIdle;
        hcnt_d      = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      hcnt_q      <= 2'd0;
      di_q        <= 8'd0;
      wclo_q      <= 8'd0;
      wchi_q      <= 8'd0;
      rem_q       <= 16'd0;
      crc_q       <= 16'hFFFF;
      crc_lo_q    <= 8'd0;
      hdr_valid_q <= 1'b0;
      hdr_vc_q    <= 2'd0;
      hdr_dt_q    <= 6'd0;
      hdr_wc_q    <= 16'd0;
      hdr_long_q  <= 1'b0;
      ecc_corr_q  <= 1'b0;
      ecc_err_q   <= 1'b0;
      wc_err_q    <= 1'b0;
      pl_valid_q  <= 1'b0;
      pl_data_q   <= 8'd0;
      pl_last_q   <= 1'b0;
      pkt_done_q  <= 1'b0;
      crc_ok_q    <= 1'b0;
      err_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      di_q        <= di_d;
      wclo_q      <= wclo_d;
      wchi_q      <= wchi_d;
      rem_q       <= rem_d;
      crc_q       <= crc_d;
      crc_lo_q    <= crc_lo_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_vc_q    <= hdr_vc_d;
      hdr_dt_q    <= hdr_dt_d;
      hdr_wc_q    <= hdr_wc_d;
      hdr_long_q  <= hdr_long_d;
      ecc_corr_q  <= ecc_corr_d;
      ecc_err_q   <= ecc_err_d;
      wc_err_q    <= wc_err_d;
      pl_valid_q  <= pl_valid_d;
      pl_data_q   <= pl_data_d;
      pl_last_q   <= pl_last_d;
      pkt_done_q  <= pkt_done_d;
      crc_ok_q    <= crc_ok_d;
      err_trunc_q <= err_trunc_d;
    end
  end

  assign hdr_valid = hdr_valid_q;
  assign hdr_vc    = hdr_vc_q;
  assign hdr_dt    = hdr_dt_q;
  assign hdr_wc    = hdr_wc_q;
  assign hdr_long  = hdr_long_q;
  assign ecc_corr  = ecc_corr_q;
  assign ecc_err   = ecc_err_q;
  assign wc_err    = wc_err_q;
  assign pl_valid  = pl_valid_q;
  assign pl_data   = pl_data_q;
  assign pl_last   = pl_last_q;
  assign pkt_done  = pkt_done_q;
  assign crc_ok    = crc_ok_q;
  assign err_trunc = err_trunc_q;

endmodule

// File: tb/tb_dsi_packet_rx.sv
// Scoreboard bench for dsi_packet_rx: directed bursts push expected events, a negedge
// monitor pops and compares every header, payload byte, completion and truncation pulse.
module tb_dsi_packet_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_sot, in_eot;
  logic [7:0]  in_data;
  logic        hdr_valid, hdr_long, ecc_corr, ecc_err, wc_err;
  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        pl_valid, pl_last, pkt_done, crc_ok, err_trunc;
  logic [7:0]  pl_data;

  dsi_packet_rx dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sot(in_sot),
    .in_eot(in_eot), .hdr_valid(hdr_valid), .hdr_vc(hdr_vc), .hdr_dt(hdr_dt),
    .hdr_wc(hdr_wc), .hdr_long(hdr_long), .ecc_corr(ecc_corr), .ecc_err(ecc_err),
    .wc_err(wc_err), .pl_valid(pl_valid), .pl_data(pl_data), .pl_last(pl_last),
    .pkt_done(pkt_done), .crc_ok(crc_ok), .err_trunc(err_trunc)
  );

  always #5 clk = ~clk;

  localparam int KHdr = 1, KPl = 2, KDone = 3, KTrunc = 4;
  typedef struct {int kind; logic [27:0] val;} exp_t;
  exp_t exp_q[$];
  int n_total = 0, n_pass = 0;
  logic [7:0] b[$];
  logic [7:0] pay[0:23];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic take(input int kind, input logic [27:0] val, input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_%s: got %h expected nothing", name, val);
    end else begin
      e = exp_q.pop_front();
      chk(name, {28'd0, 4'(kind), 4'd0, val}, {28'd0, 4'(e.kind), 4'd0, e.val});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (hdr_valid) take(KHdr, {hdr_vc, hdr_dt, hdr_wc, hdr_long, ecc_corr, ecc_err, wc_err}, "hdr");
      if (pl_valid)  take(KPl, {19'd0, pl_last, pl_data}, "pl");
      if (pkt_done)  take(KDone, {27'd0, crc_ok}, "done");
      if (err_trunc) take(KTrunc, 28'd0, "trunc");
    end
  end

  function automatic void e_hdr(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                                input logic lng, input logic cor, input logic err, input logic wce);
    exp_q.push_back('{KHdr, {vc, dt, wc, lng, cor, err, wce}});
  endfunction
  function automatic void e_pl(input logic [7:0] d, input logic last);
    exp_q.push_back('{KPl, {19'd0, last, d}});
  endfunction
  function automatic void e_done(input logic ok);
    exp_q.push_back('{KDone, {27'd0, ok}});
  endfunction
  function automatic void e_trunc();
    exp_q.push_back('{KTrunc, 28'd0});
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sot   = 1'($urandom_range(0, 1));  // must be ignored while in_valid=0
      in_eot   = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sot, input logic eot);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    in_sot   = sot;
    in_eot   = eot;
  endtask

  task automatic send_burst(input bit gaps);
    for (int i = 0; i < b.size(); i++) begin
      if (gaps) idle($urandom_range(0, 2));
      send_byte(b[i], i == 0, i == b.size() - 1);
    end
    idle(3);
  endtask

  task automatic add_long(input logic [7:0] c0, input logic [7:0] c1);
    b = {b, 8'h39, 8'h18, 8'h00, 8'h0C};
    for (int i = 0; i < 24; i++) b.push_back(pay[i]);
    b = {b, c0, c1};
  endtask

  function automatic void e_long(input logic ok);
    e_hdr(2'd0, 6'h39, 16'd24, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) e_pl(pay[i], i == 23);
    e_done(ok);
  endfunction

  function automatic logic [63:0] all_outs();
    return {22'd0, hdr_valid, hdr_vc, hdr_dt, hdr_wc, hdr_long, ecc_corr, ecc_err, wc_err,
            pl_valid, pl_data, pl_last, pkt_done, crc_ok, err_trunc};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    pay = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h1E, 8'hF0, 8'h1E, 8'hC7, 8'h4F, 8'h82, 8'h78, 8'hC5,
            8'h82, 8'hE0, 8'h8C, 8'h70, 8'hD2, 8'h3C, 8'h78, 8'hE9, 8'hFF, 8'h00, 8'h00, 8'h01};
    rst_n = 1'b0; in_valid = 1'b0; in_sot = 1'b0; in_eot = 1'b0; in_data = 8'd0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Clean short packet, VC 3 short packet
    b = {8'h08, 8'h0F, 8'h0F, 8'h01};
    e_hdr(2'd0, 6'h08, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0); e_done(1'b1); send_burst(0);
    b = {8'hC8, 8'h0F, 8'h0F, 8'h0E};
    e_hdr(2'd3, 6'h08, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0); e_done(1'b1); send_burst(0);
    // Single data-bit flip, parity-only flip, double flip, ECC[7:6] set
    b = {8'h08, 8'h0E, 8'h0F, 8'h01};
    e_hdr(2'd0, 6'h08, 16'h0F0F, 1'b0, 1'b1, 1'b0, 1'b0); e_done(1'b1); send_burst(0);
    b = {8'h08, 8'h0F, 8'h0F, 8'h03};
    e_hdr(2'd0, 6'h08, 16'h0F0F, 1'b0, 1'b1, 1'b0, 1'b0); e_done(1'b1); send_burst(0);
    b = {8'h08, 8'h0C, 8'h0F, 8'h01, 8'h08, 8'h0F, 8'h0F, 8'h01};
    e_hdr(2'd0, 6'h08, 16'h0F0C, 1'b0, 1'b0, 1'b1, 1'b0); send_burst(0);
    b = {8'h08, 8'h0F, 8'h0F, 8'h41, 8'h08, 8'h0F, 8'h0F, 8'h01};
    e_hdr(2'd0, 6'h08, 16'h0F0F, 1'b0, 1'b0, 1'b1, 1'b0); send_burst(0);

    // Long packet: good CRC, bad CRC, zero CRC
    b = {}; add_long(8'h69, 8'hE5); e_long(1'b1); send_burst(0);
    b = {}; add_long(8'h69, 8'hE4); e_long(1'b0); send_burst(0);
    b = {}; add_long(8'h00, 8'h00); e_long(1'b1); send_burst(0);
    // Long WC=0: CRC of empty payload is 0xFFFF
    b = {8'h39, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'hFF};
    e_hdr(2'd0, 6'h39, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0); e_done(1'b1); send_burst(1);

    // Short + long + short in one burst with random gaps
    b = {8'h05, 8'h11, 8'h00, 8'h36};
    add_long(8'h69, 8'hE5);
    b = {b, 8'h08, 8'h0F, 8'h0F, 8'h01};
    e_hdr(2'd0, 6'h05, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0); e_done(1'b1);
    e_long(1'b1);
    e_hdr(2'd0, 6'h08, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0); e_done(1'b1);
    send_burst(1);

    // in_eot on payload byte 10
    e_hdr(2'd0, 6'h39, 16'd24, 1'b1, 1'b0, 1'b0, 1'b0);
    b = {8'h39, 8'h18, 8'h00, 8'h0C};
    for (int i = 0; i < 10; i++) begin b.push_back(pay[i]); e_pl(pay[i], 1'b0); end
    e_trunc(); send_burst(0);

    // New in_sot mid-payload restarts with a short header
    e_hdr(2'd0, 6'h39, 16'd24, 1'b1, 1'b0, 1'b0, 1'b0);
    b = {8'h39, 8'h18, 8'h00, 8'h0C};
    for (int i = 0; i < 5; i++) begin b.push_back(pay[i]); e_pl(pay[i], 1'b0); end
    e_trunc(); e_hdr(2'd0, 6'h08, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0); e_done(1'b1);
    for (int i = 0; i < b.size(); i++) send_byte(b[i], i == 0, 1'b0);
    send_byte(8'h08, 1'b1, 1'b0); send_byte(8'h0F, 1'b0, 1'b0);
    send_byte(8'h0F, 1'b0, 1'b0); send_byte(8'h01, 1'b0, 1'b1);
    idle(3);

    // WC=5000 exceeds MAX_WC: burst skipped, then a clean packet still parses
    b = {8'h39, 8'h88, 8'h13, 8'h1A, 8'h01, 8'h02, 8'h03, 8'h04};
    e_hdr(2'd0, 6'h39, 16'd5000, 1'b1, 1'b0, 1'b0, 1'b1); send_burst(0);
    b = {8'h08, 8'h0F, 8'h0F, 8'h01};
    e_hdr(2'd0, 6'h08, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0); e_done(1'b1); send_burst(0);

    // Reset asserted mid-payload, right after a pl_valid pulse
    e_hdr(2'd0, 6'h39, 16'd24, 1'b1, 1'b0, 1'b0, 1'b0);
    b = {8'h39, 8'h18, 8'h00, 8'h0C};
    for (int i = 0; i < 5; i++) begin b.push_back(pay[i]); e_pl(pay[i], 1'b0); end
    for (int i = 0; i < b.size(); i++) send_byte(b[i], i == 0, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk("reset_mid_payload", all_outs(), 64'd0);
    idle(2);
    rst_n = 1'b1;
    b = {8'h08, 8'h0F, 8'h0F, 8'h01};
    e_hdr(2'd0, 6'h08, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0); e_done(1'b1); send_burst(0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
